ssrv_mem_bridge: RTL and testbench
==================================

# ssrv_mem_bridge

Parametrised bridge between NUM_CH SSRV-style memory requesters (fetch, load/store, future prefetch) and one SCR1 memory port (req/req_ack/resp). It generalises the fixed one-to-one imem/dmem adaptation in the pipe top. It adds three things: round-robin arbitration, up to DEPTH outstanding transactions tracked by a channel-tag FIFO, and in-order response routing back to the issuing channel. It sits between `ssrv_top` memory ports and the SCR1 memory router/TCM.

## Interface
Parameters:
- NUM_CH, 2, number of requesting channels (≥1); channel 0 has highest initial priority
- AW, 32, address width
- DW, 32, data width
- DEPTH, 2, max outstanding SCR1 transactions (≥1)

Ports:
- clk  in  1  clock
- pipe_rst_n  in  1  reset, asynchronous, active-low
- ch_req  in  NUM_CH  per-channel request; held with fields stable until ch_ready
- ch_cmd  in  NUM_CH  1 = write, 0 = read
- ch_width  in  2*NUM_CH  2'b10 word, 2'b01 half, other byte
- ch_addr  in  AW*NUM_CH  request address
- ch_wdata  in  DW*NUM_CH  write data
- ch_ready  out  NUM_CH  one-hot; request accepted this cycle
- ch_rvalid  out  NUM_CH  one-hot; response for that channel this cycle
- ch_err  out  NUM_CH  response was RDY_ER (qualified by ch_rvalid)
- ch_rdata  out  DW  shared read data, qualified by ch_rvalid
- mem_req  out  1  SCR1 request
- mem_cmd  out  type_scr1_mem_cmd_e  RD/WR
- mem_width  out  type_scr1_mem_width_e  BYTE/HWORD/WORD
- mem_addr  out  AW  address
- mem_wdata  out  DW  write data
- mem_req_ack  in  1  SCR1 request accept
- mem_rdata  in  DW  SCR1 read data
- mem_resp  in  type_scr1_mem_resp_e  IDLE/RDY_OK/RDY_ER
- busy  out  1  outstanding count ≠ 0
- proto_err  out  1  sticky: response received with no outstanding transaction

## Operation
- Arbiter: round-robin over ch_req, starting from pointer rr. mem_req = (any ch_req) & !fifo_full.
- Grant lock: if mem_req=1 and mem_req_ack=0, the granted channel is registered as locked. It is re-granted every cycle until ack, so SCR1 sees stable request fields.
- Request fields are muxed from the granted channel. Width mapping: 10→WORD, 01→HWORD, 00/11→BYTE. cmd 1→WR, 0→RD.
- Accept (mem_req & mem_req_ack):
  - ch_ready[grant]=1
  - push grant index into the tag FIFO
  - rr ← (grant+1) mod NUM_CH
  - lock cleared
- Response (mem_resp ∈ {RDY_OK, RDY_ER}) with FIFO non-empty:
  - pop head tag
  - ch_rvalid[head]=1, ch_rdata=mem_rdata
  - ch_err[head]=(mem_resp==RDY_ER)
- Response with FIFO empty: dropped, proto_err←1 (cleared only by reset).
- Simultaneous accept and response: push and pop both happen, count unchanged. Full blocks mem_req even if a pop occurs that cycle (no bypass).
- Responses are strictly in order; SCR1 port is assumed in-order.

## Timing
- Reset values: mem_req=0, ch_ready=0, ch_rvalid=0, ch_err=0, busy=0, proto_err=0, rr=0, lock=0, FIFO empty, count=0.
- Request path is combinational (ch_req→mem_req same cycle); zero added latency.
- Response path is combinational (mem_resp→ch_rvalid same cycle).
- Throughput: one accept per cycle when mem_req_ack is tied high and the FIFO is not full.
- FIFO pointers wrap modulo DEPTH; count width $clog2(DEPTH+1); tag width max(1,$clog2(NUM_CH)).
- Reset mid-transaction: all outstanding tags are discarded. A late SCR1 response after reset sets proto_err.
- Outputs other than registered state flags are combinational of the current inputs plus state; no X is driven when mem_req=0 (fields default to channel 0).

## Structure
- Package ssrv_mem_bridge_pkg holds:
  - width-encoding localparams (W_BYTE/W_HALF/W_WORD)
  - the encoding→type_scr1_mem_width_e conversion function
  - the cmd conversion function
- Sub-module ssrv_tag_fifo: DEPTH×tag-width synchronous FIFO with push, pop, full, empty, head, and the same clk/pipe_rst_n.
- Arbiter and lock stay in the top-level block.

## Test plan
- Single channel, ack tied 1: ch_req[0] read addr 0x100 width 10 → same-cycle mem_req, mem_cmd=RD, mem_width=WORD, ch_ready[0]=1. RDY_OK rdata 0xDEADBEEF next cycle → ch_rvalid=01, ch_rdata=0xDEADBEEF.
- Both channels requesting continuously, ack=1, NUM_CH=2 → grants alternate 0,1,0,1. Responses return ch_rvalid 01,10,01,10 in issue order.
- Ack held low 3 cycles while ch_req[1] also rises → grant stays on channel 0, fields stable, ch_ready[0] only on the ack cycle.
- DEPTH=2: two accepts without responses → mem_req=0 despite ch_req. Response with RDY_ER → ch_err set for the oldest tag; mem_req=1 next cycle.
- mem_resp=RDY_OK with busy=0 → no ch_rvalid, proto_err=1 and stays 1. Assert pipe_rst_n=0 mid-stream → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/ssrv_mem_bridge_pkg.sv
// ssrv_mem_bridge_pkg: SCR1 memory-port types and SSRV-to-SCR1 encoding helpers
// Exports: cmd/width/resp enums, W_* width encodings, conv_width(), conv_cmd().
package ssrv_mem_bridge_pkg;
  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;
  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;
  // NOTRDY is the idle (no response) encoding of the SCR1 port
  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;
  // 00 and 11 both fall through to byte
  function automatic type_scr1_mem_width_e conv_width(input logic [1:0] w);
    return w == W_WORD ? SCR1_MEM_WIDTH_WORD : w == W_HALF ? SCR1_MEM_WIDTH_HWORD : SCR1_MEM_WIDTH_BYTE;
  endfunction
  function automatic type_scr1_mem_cmd_e conv_cmd(input logic c);
    return c ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
  endfunction
endpackage

// File: rtl/ssrv_mem_bridge_if.sv
// ssrv_mem_bridge_if: SCR1 memory port bundle
// master: drives mem_req/cmd/width/addr/wdata, receives mem_req_ack/rdata/resp.
// slave: the memory side, opposite directions.
interface ssrv_mem_bridge_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  import ssrv_mem_bridge_pkg::*;
  logic                 mem_req;
  type_scr1_mem_cmd_e   mem_cmd;
  type_scr1_mem_width_e mem_width;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic                 mem_req_ack;
  logic [DW-1:0]        mem_rdata;
  type_scr1_mem_resp_e  mem_resp;
  modport master (
    output mem_req, mem_cmd, mem_width, mem_addr, mem_wdata,
    input  mem_req_ack, mem_rdata, mem_resp
  );
  modport slave (
    input  mem_req, mem_cmd, mem_width, mem_addr, mem_wdata,
    output mem_req_ack, mem_rdata, mem_resp
  );
endinterface

// File: rtl/ssrv_tag_fifo.sv
// ssrv_tag_fifo: DEPTH x W synchronous FIFO holding channel tags of outstanding transactions
// Ports: clk, pipe_rst_n (async active-low), push/din, pop/head, full, empty.
module ssrv_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         pipe_rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic          wr, rd;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return int'(p) == DEPTH - 1 ? '0 : p + 1'b1;
  endfunction
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head  = mem[rp];
  assign wr    = push & ~full;
  assign rd    = pop & ~empty;
  always_ff @(posedge clk or negedge pipe_rst_n)
    if (!pipe_rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= inc(wp);
      if (rd) rp <= inc(rp);
      count <= count + CW'(wr) - CW'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/ssrv_mem_bridge.sv
// ssrv_mem_bridge: round-robin bridge from NUM_CH SSRV memory requesters to one SCR1 memory port
// Ports: clk, pipe_rst_n (async active-low); ch_* per-channel request/response vectors;
// mem (SCR1 port, master modport); busy (transactions outstanding); proto_err (sticky orphan response).
module ssrv_mem_bridge
  import ssrv_mem_bridge_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 pipe_rst_n,
  input  logic [NUM_CH-1:0]    ch_req,
  input  logic [NUM_CH-1:0]    ch_cmd,
  input  logic [2*NUM_CH-1:0]  ch_width,
  input  logic [AW*NUM_CH-1:0] ch_addr,
  input  logic [DW*NUM_CH-1:0] ch_wdata,
  output logic [NUM_CH-1:0]    ch_ready,
  output logic [NUM_CH-1:0]    ch_rvalid,
  output logic [NUM_CH-1:0]    ch_err,
  output logic [DW-1:0]        ch_rdata,
  ssrv_mem_bridge_if.master    mem,
  output logic                 busy,
  output logic                 proto_err
);
  localparam int TW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [TW-1:0] rr, lock_ch, grant, idx, head;
  logic          lock, full, empty, accept, resp_v, pop;
  // Scan downward so the lowest offset from rr is the last (winning) assignment;
  // a pending unacknowledged request keeps its channel regardless of rr.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = TW'((int'(rr) + i) % NUM_CH);
      if (ch_req[idx]) grant = idx;
    end
    if (lock) grant = lock_ch;
  end
  // Reset gates mem_req so the port is quiet even while requesters still drive ch_req
  assign mem.mem_req   = pipe_rst_n & |ch_req & ~full;
  assign mem.mem_cmd   = conv_cmd(ch_cmd[grant]);
  assign mem.mem_width = conv_width(ch_width[2*int'(grant) +: 2]);
  assign mem.mem_addr  = ch_addr[AW*int'(grant) +: AW];
  assign mem.mem_wdata = ch_wdata[DW*int'(grant) +: DW];
  assign accept    = mem.mem_req & mem.mem_req_ack;
  assign resp_v    = mem.mem_resp == SCR1_MEM_RESP_RDY_OK || mem.mem_resp == SCR1_MEM_RESP_RDY_ER;
  assign pop       = resp_v & ~empty;
  assign ch_ready  = accept ? NUM_CH'(1) << grant : '0;
  assign ch_rvalid = pop ? NUM_CH'(1) << head : '0;
  assign ch_err    = mem.mem_resp == SCR1_MEM_RESP_RDY_ER ? ch_rvalid : '0;
  assign ch_rdata  = mem.mem_rdata;
  assign busy      = ~empty;
  always_ff @(posedge clk or negedge pipe_rst_n)
    if (!pipe_rst_n) begin
      rr        <= '0;
      lock      <= 1'b0;
      lock_ch   <= '0;
      proto_err <= 1'b0;
    end else begin
      if (accept) rr <= int'(grant) == NUM_CH - 1 ? '0 : grant + 1'b1;
      lock    <= mem.mem_req & ~mem.mem_req_ack;
      lock_ch <= grant;
      if (resp_v & empty) proto_err <= 1'b1;
    end
  ssrv_tag_fifo #(.DEPTH(DEPTH), .W(TW)) u_fifo (
    .clk        (clk),
    .pipe_rst_n (pipe_rst_n),
    .push       (accept),
    .pop        (pop),
    .din        (grant),
    .head       (head),
    .full       (full),
    .empty      (empty)
  );
endmodule

// File: tb/tb_ssrv_mem_bridge.sv
// tb_ssrv_mem_bridge: directed self-checking bench for ssrv_mem_bridge with a tag scoreboard
module tb_ssrv_mem_bridge;
  import ssrv_mem_bridge_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ch_req, ch_cmd, ch_ready, ch_rvalid, ch_err;
  logic [3:0]  ch_width;
  logic [63:0] ch_addr, ch_wdata;
  logic [31:0] ch_rdata;
  logic        busy, proto_err;
  int          n_assert = 0, n_fail = 0, rr_m = 0, e;
  int          q[$];
  ssrv_mem_bridge_if #(.AW(32), .DW(32)) mif ();
  ssrv_mem_bridge #(.NUM_CH(2), .AW(32), .DW(32), .DEPTH(2)) dut (
    .clk        (clk),
    .pipe_rst_n (rst_n),
    .ch_req     (ch_req),
    .ch_cmd     (ch_cmd),
    .ch_width   (ch_width),
    .ch_addr    (ch_addr),
    .ch_wdata   (ch_wdata),
    .ch_ready   (ch_ready),
    .ch_rvalid  (ch_rvalid),
    .ch_err     (ch_err),
    .ch_rdata   (ch_rdata),
    .mem        (mif.master),
    .busy       (busy),
    .proto_err  (proto_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_resp(input string tag, input logic [31:0] data, input logic is_err);
    e = q.pop_front();
    chk({tag, "_rvalid"}, ch_rvalid, 64'(2'b01 << e));
    chk({tag, "_err"}, ch_err, is_err ? 64'(2'b01 << e) : 64'd0);
    chk({tag, "_rdata"}, ch_rdata, data);
  endtask
  initial begin
    rst_n = 1'b0;
    ch_req = 2'b11;
    ch_cmd = 2'b10;
    ch_width = {2'b01, 2'b10};
    ch_addr = {32'h200, 32'h100};
    ch_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
    mif.mem_req_ack = 1'b1;
    mif.mem_resp = SCR1_MEM_RESP_NOTRDY;
    mif.mem_rdata = '0;
    #3;
    chk("rst_mem_req", mif.mem_req, 0);
    chk("rst_ready", ch_ready, 0);
    chk("rst_rvalid", ch_rvalid, 0);
    chk("rst_err", ch_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_proto", proto_err, 0);
    ch_req = 2'b00;
    #10 rst_n = 1'b1;
    cyc();
    ch_req = 2'b01;
    #1;
    chk("t1_mem_req", mif.mem_req, 1);
    chk("t1_cmd", mif.mem_cmd, SCR1_MEM_CMD_RD);
    chk("t1_width", mif.mem_width, SCR1_MEM_WIDTH_WORD);
    chk("t1_addr", mif.mem_addr, 32'h100);
    chk("t1_ready", ch_ready, 2'b01);
    q.push_back(0);
    rr_m = 1;
    cyc();
    ch_req = 2'b00;
    mif.mem_resp = SCR1_MEM_RESP_RDY_OK;
    mif.mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk_resp("t1_resp", 32'hDEAD_BEEF, 1'b0);
    cyc();
    mif.mem_resp = SCR1_MEM_RESP_NOTRDY;
    #1;
    chk("t1_busy", busy, 0);
    for (int k = 0; k < 5; k++) begin
      ch_req = k < 4 ? 2'b11 : 2'b00;
      mif.mem_resp = k > 0 ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;
      mif.mem_rdata = 32'h1000 + k;
      #1;
      if (k > 0) chk_resp("t2_resp", 32'h1000 + k, 1'b0);
      if (k < 4) begin
        chk("t2_ready", ch_ready, 64'(2'b01 << rr_m));
        chk("t2_addr", mif.mem_addr, rr_m == 1 ? 32'h200 : 32'h100);
        chk("t2_cmd", mif.mem_cmd, rr_m == 1 ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD);
        q.push_back(rr_m);
        rr_m ^= 1;
      end
      cyc();
    end
    mif.mem_resp = SCR1_MEM_RESP_NOTRDY;
    mif.mem_req_ack = 1'b0;
    ch_req = 2'b01;
    #1;
    chk("t3_mem_req", mif.mem_req, 1);
    chk("t3_ready0", ch_ready, 0);
    cyc();
    ch_req = 2'b11;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t3_lock_addr", mif.mem_addr, 32'h100);
      chk("t3_lock_width", mif.mem_width, SCR1_MEM_WIDTH_WORD);
      chk("t3_ready", ch_ready, 0);
      cyc();
    end
    mif.mem_req_ack = 1'b1;
    #1;
    chk("t3_ack_ready", ch_ready, 2'b01);
    q.push_back(0);
    rr_m = 1;
    cyc();
    ch_req = 2'b10;
    #1;
    chk("t4_ready1", ch_ready, 2'b10);
    q.push_back(1);
    rr_m = 0;
    cyc();
    ch_req = 2'b11;
    #1;
    chk("t4_full_req", mif.mem_req, 0);
    chk("t4_full_ready", ch_ready, 0);
    chk("t4_busy", busy, 1);
    cyc();
    mif.mem_resp = SCR1_MEM_RESP_RDY_ER;
    mif.mem_rdata = 32'h55;
    #1;
    chk_resp("t4_er", 32'h55, 1'b1);
    chk("t4_no_bypass", mif.mem_req, 0);
    cyc();
    mif.mem_resp = SCR1_MEM_RESP_NOTRDY;
    #1;
    chk("t4_req_after", mif.mem_req, 1);
    chk("t4_ready_after", ch_ready, 64'(2'b01 << rr_m));
    q.push_back(rr_m);
    rr_m ^= 1;
    cyc();
    ch_req = 2'b00;
    for (int k = 0; k < 2; k++) begin
      mif.mem_resp = SCR1_MEM_RESP_RDY_OK;
      mif.mem_rdata = 32'h2000 + k;
      #1;
      chk_resp("t4_drain", 32'h2000 + k, 1'b0);
      cyc();
    end
    mif.mem_resp = SCR1_MEM_RESP_RDY_OK;
    #1;
    chk("t5_orphan_rvalid", ch_rvalid, 0);
    chk("t5_busy", busy, 0);
    cyc();
    mif.mem_resp = SCR1_MEM_RESP_NOTRDY;
    #1;
    chk("t5_proto", proto_err, 1);
    cyc();
    chk("t5_proto_sticky", proto_err, 1);
    ch_req = 2'b01;
    #1;
    chk("t5_ready", ch_ready, 2'b01);
    q.push_back(0);
    cyc();
    mif.mem_req_ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_mem_req", mif.mem_req, 0);
    chk("t5_rst_ready", ch_ready, 0);
    chk("t5_rst_rvalid", ch_rvalid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_proto", proto_err, 0);
    q.delete();
    cyc();
    rst_n = 1'b1;
    ch_req = 2'b00;
    cyc();
    mif.mem_resp = SCR1_MEM_RESP_RDY_OK;
    #1;
    chk("t5_late_rvalid", ch_rvalid, 0);
    cyc();
    mif.mem_resp = SCR1_MEM_RESP_NOTRDY;
    #1;
    chk("t5_late_proto", proto_err, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
